// File: rtl/fsm_led_monitor_pkg.sv
// Shared LED codes and state indices for the 5-state switch-driven fsm and its monitor.
// Replaces the old fsm_defs.vh include.
package fsm_led_monitor_pkg;

  localparam logic [2:0] LED_IDLE = 3'b000;
  localparam logic [2:0] LED_ST1  = 3'b001;
  localparam logic [2:0] LED_ST2  = 3'b010;
  localparam logic [2:0] LED_ST3  = 3'b100;
  localparam logic [2:0] LED_ST4  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST1     = 3'd1,
    S_ST2     = 3'd2,
    S_ST3     = 3'd3,
    S_ST4     = 3'd4,
    S_INVALID = 3'd7
  } state_idx_e;

  function automatic state_idx_e decode_led(input logic [2:0] led);
    state_idx_e idx;
    case (led)
      LED_IDLE: idx = S_IDLE;
      LED_ST1:  idx = S_ST1;
      LED_ST2:  idx = S_ST2;
      LED_ST3:  idx = S_ST3;
      LED_ST4:  idx = S_ST4;
      default:  idx = S_INVALID;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/fsm_trans_checker.sv
// Combinational legality check of a state-index transition against the fsm's transition table.
module fsm_trans_checker
  import fsm_led_monitor_pkg::*;
(
  input  logic [2:0] from_idx,
  input  logic [2:0] to_idx,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    if (from_idx == to_idx) begin
      legal = 1'b1;
    end else begin
      case ({from_idx, to_idx})
        {S_IDLE, S_ST1},
        {S_IDLE, S_ST2},
        {S_ST1,  S_ST2},
        {S_ST1,  S_ST3},
        {S_ST2,  S_ST3},
        {S_ST3,  S_ST4},
        {S_ST3,  S_IDLE},
        {S_ST4,  S_ST3}: legal = 1'b1;
        default:         legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fsm_led_monitor.sv
// Observer on the fsm LED output: decodes state, reports transitions, counts them,
// measures dwell time and raises sticky error flags.
module fsm_led_monitor
  import fsm_led_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DWELL_W     = 16,
  parameter int unsigned DWELL_LIMIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         led_in,
  input  logic               clear,
  output logic [2:0]         state_idx,
  output logic               trans_valid,
  output logic [2:0]         trans_from,
  output logic [2:0]         trans_to,
  output logic [CNT_W-1:0]   trans_count,
  output logic [DWELL_W-1:0] dwell_cnt,
  output logic [DWELL_W-1:0] dwell_max,
  output logic               err_illegal,
  output logic               err_code,
  output logic               err_timeout
);

  localparam logic [DWELL_W-1:0] TIMEOUT_AT = DWELL_W'(DWELL_LIMIT - 1);

  logic [2:0]         led_q;
  state_idx_e         cur_q;
  state_idx_e         state_q;
  logic               trans_valid_q;
  logic [2:0]         from_q;
  logic [2:0]         to_q;
  logic [CNT_W-1:0]   count_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_max_q;
  logic               err_illegal_q;
  logic               err_code_q;
  logic               err_timeout_q;

  state_idx_e         led_idx;
  logic               code_ok;
  logic               changed;
  logic               legal;
  logic [CNT_W-1:0]   count_inc;
  logic [DWELL_W-1:0] dwell_inc;

  always_comb begin
    led_idx   = decode_led(led_q);
    code_ok   = (led_idx != S_INVALID);
    changed   = code_ok && (led_idx != cur_q);
    count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);
  end

  fsm_trans_checker u_checker (
    .from_idx (cur_q),
    .to_idx   (led_idx),
    .legal    (legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q         <= LED_IDLE;
      cur_q         <= S_IDLE;
      state_q       <= S_IDLE;
      trans_valid_q <= 1'b0;
      from_q        <= '0;
      to_q          <= '0;
      count_q       <= '0;
      dwell_q       <= '0;
      dwell_max_q   <= '0;
      err_illegal_q <= 1'b0;
      err_code_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      led_q         <= led_in;
      state_q       <= led_idx;
      trans_valid_q <= changed;
      // Invalid codes never move cur_q, so the next valid code is judged against the last valid state.
      if (changed) begin
        from_q <= cur_q;
        to_q   <= led_idx;
        cur_q  <= led_idx;
      end
      if (clear) begin
        count_q       <= '0;
        dwell_q       <= '0;
        dwell_max_q   <= '0;
        err_illegal_q <= 1'b0;
        err_code_q    <= 1'b0;
        err_timeout_q <= 1'b0;
      end else begin
        if (changed) begin
          dwell_q <= '0;
          if (legal) count_q <= count_inc;
          else       err_illegal_q <= 1'b1;
        end else begin
          dwell_q <= dwell_inc;
          if (dwell_inc > dwell_max_q) dwell_max_q <= dwell_inc;
        end
        if (!code_ok) err_code_q <= 1'b1;
        if ((cur_q != S_IDLE) && (dwell_q == TIMEOUT_AT)) err_timeout_q <= 1'b1;
      end
    end
  end

  assign state_idx   = state_q;
  assign trans_valid = trans_valid_q;
  assign trans_from  = from_q;
  assign trans_to    = to_q;
  assign trans_count = count_q;
  assign dwell_cnt   = dwell_q;
  assign dwell_max   = dwell_max_q;
  assign err_illegal = err_illegal_q;
  assign err_code    = err_code_q;
  assign err_timeout = err_timeout_q;

endmodule
